rmii_rx_deser: RTL and testbench
================================

RMII_RX_DESER -- requirements
Module: rmii_rx_deser

Interface
REQ-001 clk  input  1  50 MHz RMII reference clock; sole clock; all logic rising-edge.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 phy_rmii_crsdv  input  1  PHY carrier-sense/data-valid.
REQ-004 phy_rmii_rxd  input  2  PHY receive dibit; bit 0 is first on the wire.
REQ-005 phy_rmii_rxer  input  1  PHY receive error.
REQ-006 rx_data  output  8  received byte, LSB-first dibit assembly.
REQ-007 rx_valid  output  1  one-cycle strobe; rx_data, rx_er and rx_sof are valid.
REQ-008 rx_er  output  1  byte contained at least one dibit with rxer=1.
REQ-009 rx_sof  output  1  marks the first byte after SFD; qualified by rx_valid.
REQ-010 rx_eof  output  1  one-cycle pulse after the last byte of a frame; never coincident with rx_valid.
REQ-011 stat_align_err  output  1  one-cycle pulse when a frame ends on a partial byte.
REQ-012 stat_preamble_err  output  1  one-cycle pulse when the preamble exceeds the limit.

Function
REQ-013 Inputs shall be registered once (IOB stage) before any use; all outputs shall be registered.
REQ-014 FSM states shall be IDLE, PREAMBLE, DATA and DROP.
REQ-015 IDLE: crsdv=1 and rxd=2'b01 -> PREAMBLE; anything else stays in IDLE.
REQ-016 PREAMBLE, per dibit:
- crsdv=0 -> IDLE.
- rxd=01 -> increment the preamble counter.
- rxd=11 (SFD) -> DATA with dibit index 0.
- rxd=00 or 10 -> DROP.
REQ-017 PREAMBLE counter exceeding PREAMBLE_MAX_DIBITS (32) shall pulse stat_preamble_err and go to DROP.
REQ-018 DATA: dibit k (k=0..3) shall load byte bits [2k+1:2k]; index 3 shall wrap to 0.
REQ-019 rx_valid shall assert two cycles after the index-3 dibit is present at the pins (one cycle in the IOB, one in the output register).
REQ-020 rx_er shall be the OR of registered rxer over the four dibits of the byte.
REQ-021 rx_sof shall be 1 only with the first rx_valid of a frame.
REQ-022 End of frame: crsdv=0 sampled at dibit index 0 or 2 -> IDLE and pulse rx_eof one cycle after the final rx_valid (or the next cycle if there is none).
REQ-023 crsdv=0 at index 1 or 3 shall be treated as RMII carrier-toggle and ignored; that dibit is still accepted as data.
REQ-024 End at index 2 shall discard the partial byte and pulse stat_align_err together with rx_eof.
REQ-025 DROP shall ignore data and return to IDLE on the first cycle with crsdv=0; no rx_valid or rx_eof is produced.
REQ-026 crsdv rising in the same cycle the FSM enters IDLE shall be evaluated by IDLE on the next dibit; no dibit is double-counted.

Reset
REQ-027 While reset_n=0, the state shall be IDLE and all counters and outputs 0.
REQ-028 Reset asserted mid-frame shall drop the frame silently (no rx_eof); after release the FSM waits in IDLE for a new preamble.

Configuration
REQ-029 Macro RMII_RX_10M_EN defined: add input speed_10 (1 bit), placed after phy_rmii_rxer.
- speed_10=1: each dibit is held 10 clocks; a sample strobe fires on clock 5 of each 10, with the phase counter cleared on registered crsdv rising.
- All FSM rules above apply per strobe; the REQ-019 latency is measured from the strobe cycle.
REQ-030 Macro undefined: no speed_10 port; every clock is a dibit (100 Mb/s only).

Structure
REQ-031 Package rmii_pkg shall hold:
- state enum;
- dibit constants PREAMBLE_DIBIT=2'b01 and SFD_DIBIT=2'b11;
- PREAMBLE_MAX_DIBITS=32.
REQ-032 Sub-module rmii_dibit_strobe (divide-by-10 strobe generator) shall be instantiated only under RMII_RX_10M_EN; otherwise the strobe is tied to 1.

Verification
REQ-033 Frame of 7x55 + D5 + bytes 0x12,0x34,0xAB, crsdv then low:
- 3 rx_valid strobes, data 0x12, 0x34, 0xAB;
- rx_sof on 0x12 only;
- one rx_eof; no error pulses.
REQ-034 rxer=1 on one dibit of the second byte -> that byte has rx_er=1; the other bytes have rx_er=0.
REQ-035 crsdv toggling 0/1 at index 1/3 for the final two bytes, then 0 at index 0 -> all bytes delivered, one rx_eof.
REQ-036 Frame ending after 2 dibits of byte 4 -> 3 bytes delivered, stat_align_err and rx_eof in the same cycle.
REQ-037 40 preamble dibits without SFD -> stat_preamble_err on dibit 33, no rx_valid until crsdv low and a new frame arrives.
REQ-038 reset_n pulsed low mid-byte 2 -> all outputs 0 immediately; no rx_eof; the following clean frame is received correctly.
REQ-039 With RMII_RX_10M_EN and speed_10=1, the REQ-033 frame with each dibit held 10 clocks -> identical byte sequence.

Source files
------------

// File: rtl/rmii_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rmii_pkg
//  Description : Shared types and constants for the RMII receive
//                deserialiser. It holds the receive FSM state enum, the
//                preamble and SFD dibit codes, the preamble length limit,
//                and a helper that decides where a frame may end.
//  Revision    : 1.0  initial release
// ============================================================================
package rmii_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        DROP     = 2'd3
    } rx_state_t;

    localparam logic [1:0]  PREAMBLE_DIBIT      = 2'b01;
    localparam logic [1:0]  SFD_DIBIT           = 2'b11;
    localparam int unsigned PREAMBLE_MAX_DIBITS = 32;
    localparam int unsigned PRE_CNT_W           = $clog2(PREAMBLE_MAX_DIBITS + 1);

    // A frame can only end on a byte or half-byte boundary (index 0 or 2).
    // Carrier loss at index 1 or 3 is the RMII CRS_DV toggle and is not an end.
    function automatic logic frame_ends(input logic crsdv, input logic [1:0] idx);
        return !crsdv && !idx[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rmii_dibit_strobe.sv
`default_nettype none
// ============================================================================
//  Module      : rmii_dibit_strobe
//  Description : Dibit sample strobe for 10 Mb/s RMII. In 10 Mb/s mode each
//                dibit is held for DIV clocks, and the strobe fires once per
//                dibit on phase STROBE_PHASE (clock 5 of 10). The phase is
//                re-zeroed in the cycle where registered CRS_DV rises, which
//                keeps the strobe centred on the dibits of the new frame. In
//                100 Mb/s mode the strobe is held at 1.
//                The module is defined only when RMII_RX_10M_EN is set. That
//                is the only build that instantiates it.
//  Ports       : clk         clock
//                reset_n     asynchronous active-low reset
//                i_crsdv     registered CRS_DV
//                i_speed_10  1 = 10 Mb/s mode
//                o_strobe    dibit sample strobe
//  Revision    : 1.0  initial release
// ============================================================================
`ifdef RMII_RX_10M_EN
module rmii_dibit_strobe #(
    parameter int unsigned DIV          = 10,
    parameter int unsigned STROBE_PHASE = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_crsdv,
    input  logic i_speed_10,
    output logic o_strobe
);

    localparam int unsigned c_PH_W = $clog2(DIV);

    logic              r_crsdv_d;
    logic [c_PH_W-1:0] r_phase;
    logic              w_rise;
    logic [c_PH_W-1:0] w_phase;

    assign w_rise   = i_crsdv && !r_crsdv_d;
    // The rising-edge cycle itself is phase 0 (clock 1 of the dibit).
    assign w_phase  = w_rise ? '0 : r_phase;
    assign o_strobe = i_speed_10 ? (w_phase == c_PH_W'(STROBE_PHASE)) : 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_crsdv_d <= 1'b0;
            r_phase   <= '0;
        end else begin
            r_crsdv_d <= i_crsdv;
            r_phase   <= (w_phase == c_PH_W'(DIV - 1)) ? '0 : w_phase + 1'b1;
        end
    end

endmodule
`endif
`default_nettype wire

// File: rtl/rmii_rx_deser.sv
`default_nettype none
// ============================================================================
//  Module      : rmii_rx_deser
//  Description : RMII receive deserialiser. It registers the PHY pins once,
//                then finds the preamble and SFD and assembles dibits into
//                bytes LSB first. It flags frame start and end, dibit errors,
//                misaligned frame ends and over-long preambles.
//                Build option RMII_RX_10M_EN adds the speed_10 input and a
//                divide-by-10 dibit strobe for 10 Mb/s operation.
//  Ports       : clk                50 MHz RMII reference clock
//                reset_n            asynchronous active-low reset
//                phy_rmii_crsdv     PHY carrier sense / data valid
//                phy_rmii_rxd[1:0]  PHY receive dibit, bit 0 first on wire
//                phy_rmii_rxer      PHY receive error
//                speed_10           (RMII_RX_10M_EN only) 1 = 10 Mb/s
//                rx_data[7:0]       received byte
//                rx_valid           one-cycle byte strobe
//                rx_er              byte contained an rxer dibit
//                rx_sof             first byte of the frame (with rx_valid)
//                rx_eof             one-cycle end-of-frame pulse
//                stat_align_err     frame ended on a half byte
//                stat_preamble_err  preamble exceeded the limit
//  Revision    : 1.0  initial release
// ============================================================================
module rmii_rx_deser
    import rmii_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       phy_rmii_crsdv,
    input  logic [1:0] phy_rmii_rxd,
    input  logic       phy_rmii_rxer,
`ifdef RMII_RX_10M_EN
    input  logic       speed_10,
`endif
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_er,
    output logic       rx_sof,
    output logic       rx_eof,
    output logic       stat_align_err,
    output logic       stat_preamble_err
);

    // Input (IOB) stage
    logic       r_crsdv;
    logic [1:0] r_rxd;
    logic       r_rxer;

    // FSM and datapath state
    rx_state_t          r_state, w_state_nxt;
    logic [PRE_CNT_W-1:0] r_pre_cnt, w_pre_cnt_nxt;
    logic [1:0]         r_idx, w_idx_nxt;
    logic [5:0]         r_shift, w_shift_nxt;
    logic               r_er_acc, w_er_acc_nxt;
    logic               r_first, w_first_nxt;

    // Next values for the registered outputs
    logic [7:0] w_data_nxt;
    logic       w_valid_nxt;
    logic       w_er_nxt;
    logic       w_sof_nxt;
    logic       w_eof_nxt;
    logic       w_align_nxt;
    logic       w_pre_err_nxt;

    logic       w_strobe;

`ifdef RMII_RX_10M_EN
    rmii_dibit_strobe #(
        .DIV          (10),
        .STROBE_PHASE (4)
    ) u_strobe (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_crsdv    (r_crsdv),
        .i_speed_10 (speed_10),
        .o_strobe   (w_strobe)
    );
`else
    assign w_strobe = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_crsdv <= 1'b0;
            r_rxd   <= 2'b00;
            r_rxer  <= 1'b0;
        end else begin
            r_crsdv <= phy_rmii_crsdv;
            r_rxd   <= phy_rmii_rxd;
            r_rxer  <= phy_rmii_rxer;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state           <= IDLE;
            r_pre_cnt         <= '0;
            r_idx             <= 2'd0;
            r_shift           <= 6'd0;
            r_er_acc          <= 1'b0;
            r_first           <= 1'b0;
            rx_data           <= 8'd0;
            rx_valid          <= 1'b0;
            rx_er             <= 1'b0;
            rx_sof            <= 1'b0;
            rx_eof            <= 1'b0;
            stat_align_err    <= 1'b0;
            stat_preamble_err <= 1'b0;
        end else begin
            r_state           <= w_state_nxt;
            r_pre_cnt         <= w_pre_cnt_nxt;
            r_idx             <= w_idx_nxt;
            r_shift           <= w_shift_nxt;
            r_er_acc          <= w_er_acc_nxt;
            r_first           <= w_first_nxt;
            rx_data           <= w_data_nxt;
            rx_valid          <= w_valid_nxt;
            rx_er             <= w_er_nxt;
            rx_sof            <= w_sof_nxt;
            rx_eof            <= w_eof_nxt;
            stat_align_err    <= w_align_nxt;
            stat_preamble_err <= w_pre_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pre_cnt_nxt = r_pre_cnt;
        w_idx_nxt     = r_idx;
        w_shift_nxt   = r_shift;
        w_er_acc_nxt  = r_er_acc;
        w_first_nxt   = r_first;
        w_data_nxt    = rx_data;
        w_valid_nxt   = 1'b0;
        w_er_nxt      = 1'b0;
        w_sof_nxt     = 1'b0;
        w_eof_nxt     = 1'b0;
        w_align_nxt   = 1'b0;
        w_pre_err_nxt = 1'b0;

        if (w_strobe) begin
            case (r_state)
                IDLE: begin
                    // The dibit that opens the preamble counts as dibit 1.
                    if (r_crsdv && (r_rxd == PREAMBLE_DIBIT)) begin
                        w_state_nxt   = PREAMBLE;
                        w_pre_cnt_nxt = PRE_CNT_W'(1);
                    end
                end

                PREAMBLE: begin
                    if (!r_crsdv) begin
                        w_state_nxt = IDLE;
                    end else if (r_rxd == PREAMBLE_DIBIT) begin
                        if (r_pre_cnt == PRE_CNT_W'(PREAMBLE_MAX_DIBITS)) begin
                            w_pre_err_nxt = 1'b1;
                            w_state_nxt   = DROP;
                        end else begin
                            w_pre_cnt_nxt = r_pre_cnt + 1'b1;
                        end
                    end else if (r_rxd == SFD_DIBIT) begin
                        w_state_nxt = DATA;
                        w_idx_nxt   = 2'd0;
                        w_first_nxt = 1'b1;
                    end else begin
                        w_state_nxt = DROP;
                    end
                end

                DATA: begin
                    if (frame_ends(r_crsdv, r_idx)) begin
                        // A half-assembled byte at index 2 is discarded.
                        w_state_nxt = IDLE;
                        w_eof_nxt   = 1'b1;
                        w_align_nxt = r_idx[1];
                    end else begin
                        w_idx_nxt = r_idx + 2'd1;
                        case (r_idx)
                            2'd0: begin
                                w_shift_nxt[1:0] = r_rxd;
                                w_er_acc_nxt     = r_rxer;
                            end
                            2'd1: begin
                                w_shift_nxt[3:2] = r_rxd;
                                w_er_acc_nxt     = r_er_acc | r_rxer;
                            end
                            2'd2: begin
                                w_shift_nxt[5:4] = r_rxd;
                                w_er_acc_nxt     = r_er_acc | r_rxer;
                            end
                            default: begin
                                // The last dibit bypasses the shift register.
                                // This keeps byte latency at IOB + output register.
                                w_valid_nxt = 1'b1;
                                w_data_nxt  = {r_rxd, r_shift};
                                w_er_nxt    = r_er_acc | r_rxer;
                                w_sof_nxt   = r_first;
                                w_first_nxt = 1'b0;
                            end
                        endcase
                    end
                end

                DROP: begin
                    if (!r_crsdv) begin
                        w_state_nxt = IDLE;
                    end
                end

                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rmii_rx_deser.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_rmii_rx_deser
//  Description : Self-checking bench for rmii_rx_deser. It drives
//                frame-level vectors from a table, randomised frames scored
//                by a frame-level reference model, and hand-written reset,
//                back-to-back and (with RMII_RX_10M_EN) 10 Mb/s sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rmii_rx_deser;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       crsdv;
    logic [1:0] rxd;
    logic       rxer;
`ifdef RMII_RX_10M_EN
    logic       speed_10;
`endif
    logic [7:0] rx_data;
    logic       rx_valid, rx_er, rx_sof, rx_eof, stat_align_err, stat_preamble_err;

    rmii_rx_deser dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .phy_rmii_crsdv    (crsdv),
        .phy_rmii_rxd      (rxd),
        .phy_rmii_rxer     (rxer),
`ifdef RMII_RX_10M_EN
        .speed_10          (speed_10),
`endif
        .rx_data           (rx_data),
        .rx_valid          (rx_valid),
        .rx_er             (rx_er),
        .rx_sof            (rx_sof),
        .rx_eof            (rx_eof),
        .stat_align_err    (stat_align_err),
        .stat_preamble_err (stat_preamble_err)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- output monitor (sampled on falling edge) -------------
    logic [7:0] mon_data[$];
    bit         mon_er[$];
    bit         mon_sof[$];
    int         mon_cyc[$];
    int eof_cnt = 0, align_cnt = 0, pre_cnt = 0, ovl_cnt = 0;
    int eof_cyc = 0, align_cyc = 0, pre_cyc = 0;

    always @(negedge clk) begin
        if (rx_valid) begin
            mon_data.push_back(rx_data);
            mon_er.push_back(rx_er);
            mon_sof.push_back(rx_sof);
            mon_cyc.push_back(cyc);
        end
        if (rx_eof) begin
            eof_cnt <= eof_cnt + 1;
            eof_cyc <= cyc;
        end
        if (stat_align_err) begin
            align_cnt <= align_cnt + 1;
            align_cyc <= cyc;
        end
        if (stat_preamble_err) begin
            pre_cnt <= pre_cnt + 1;
            pre_cyc <= cyc;
        end
        if (rx_valid && rx_eof) ovl_cnt <= ovl_cnt + 1;
    end

    // ---------------- bookkeeping ----------------
    int n_cmp = 0, n_fail = 0;
    int base_v, base_eof, base_align, base_pre;
    int d_byte0_cyc, d_pre33_cyc;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic snap();
        base_v     = mon_data.size();
        base_eof   = eof_cnt;
        base_align = align_cnt;
        base_pre   = pre_cnt;
    endtask

    task automatic drive_dibit(input logic c, input logic [1:0] d, input logic e, input int hold);
        crsdv = c;
        rxd   = d;
        rxer  = e;
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one frame: pre_len preamble dibits (01), then the SFD and the data
    // dibits if the preamble is legal, then tail dibits and a carrier-off gap.
    task automatic drive_frame(input int pre_len, input int nbytes, input logic [63:0] data,
                               input logic [31:0] err_mask, input logic [31:0] tog_mask,
                               input int tail, input int gap, input int hold);
        for (int p = 1; p <= pre_len; p++) begin
            if (p == 33) d_pre33_cyc = cyc;
            drive_dibit(1'b1, 2'b01, 1'b0, hold);
        end
        if (pre_len <= 32) begin
            drive_dibit(1'b1, 2'b11, 1'b0, hold);
            for (int d = 0; d < 4 * nbytes; d++) begin
                if (d == 3) d_byte0_cyc = cyc;
                drive_dibit(!tog_mask[d], data[2*d +: 2], err_mask[d], hold);
            end
            for (int t = 0; t < tail; t++) drive_dibit(1'b1, 2'b10, 1'b0, hold);
        end
        for (int g = 0; g < gap; g++) drive_dibit(1'b0, 2'b00, 1'b0, hold);
    endtask

    task automatic check_frame(input int nvalid, input logic [63:0] exp_data, input logic [7:0] exp_er,
                               input int exp_eof, input int exp_align, input int exp_pre,
                               input int tail, input bit timing);
        int got_v;
        got_v = mon_data.size() - base_v;
        check("valid_count", got_v, nvalid);
        for (int i = 0; i < got_v && i < nvalid; i++) begin
            check("rx_data", int'(mon_data[base_v+i]), int'(exp_data[8*i +: 8]));
            check("rx_er", int'(mon_er[base_v+i]), int'(exp_er[i]));
            check("rx_sof", int'(mon_sof[base_v+i]), (i == 0) ? 1 : 0);
        end
        check("eof_count", eof_cnt - base_eof, exp_eof);
        check("align_count", align_cnt - base_align, exp_align);
        check("preamble_err_count", pre_cnt - base_pre, exp_pre);
        if (timing) begin
            if (nvalid > 0 && got_v > 0) begin
                check("valid_latency", mon_cyc[base_v] - d_byte0_cyc, 2);
                if (exp_eof == 1 && eof_cnt > base_eof)
                    check("eof_after_last_valid", eof_cyc - mon_cyc[mon_data.size()-1], 1 + tail);
            end
            if (exp_pre == 1 && pre_cnt > base_pre)
                check("preamble_err_dibit33", pre_cyc - d_pre33_cyc, 2);
            if (exp_align == 1 && align_cnt > base_align)
                check("align_with_eof", align_cyc, eof_cyc);
        end
    endtask

    // ---------------- table of frame-level vectors ----------------
    typedef struct {
        int          pre_len;
        int          nbytes;
        logic [63:0] data;
        logic [31:0] err_mask;   // rxer per data dibit
        logic [31:0] tog_mask;   // crsdv=0 per data dibit (odd indices only)
        int          tail;       // extra dibits after the last full byte
        int          exp_nvalid;
        logic [63:0] exp_data;
        logic [7:0]  exp_er;
        int          exp_eof;
        int          exp_align;
        int          exp_pre;
    } vec_t;

    vec_t vecs[9];

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [63:0] r_data, m_data;
        logic [31:0] r_err, r_tog;
        logic [7:0]  m_er;
        int          r_pre, r_nb, r_tail, m_nv, m_eof, m_align, m_pre;
        logic [7:0]  bb_exp[4];

        vecs[0] = '{31, 3, 64'h00AB3412, 32'h0,  32'h0,      0, 3, 64'h00AB3412, 8'h00, 1, 0, 0};
        vecs[1] = '{31, 3, 64'h00AB3412, 32'h20, 32'h0,      0, 3, 64'h00AB3412, 8'h02, 1, 0, 0};
        vecs[2] = '{31, 4, 64'hF00FC35A, 32'h0,  32'h0000AA00, 0, 4, 64'hF00FC35A, 8'h00, 1, 0, 0};
        vecs[3] = '{31, 3, 64'h00AB3412, 32'h0,  32'h0,      2, 3, 64'h00AB3412, 8'h00, 1, 1, 0};
        vecs[4] = '{40, 0, 64'h0,        32'h0,  32'h0,      0, 0, 64'h0,        8'h00, 0, 0, 1};
        vecs[5] = '{32, 2, 64'hA55A,     32'h80, 32'h0,      0, 2, 64'hA55A,     8'h02, 1, 0, 0};
        vecs[6] = '{33, 1, 64'h77,       32'h0,  32'h0,      0, 0, 64'h0,        8'h00, 0, 0, 1};
        vecs[7] = '{31, 0, 64'h0,        32'h0,  32'h0,      0, 0, 64'h0,        8'h00, 1, 0, 0};
        vecs[8] = '{1,  1, 64'hFF,       32'h1,  32'h0,      0, 1, 64'hFF,       8'h01, 1, 0, 0};

        // ---------------- reset state ----------------
        reset_n = 1'b0;
        crsdv   = 1'b0;
        rxd     = 2'b00;
        rxer    = 1'b0;
`ifdef RMII_RX_10M_EN
        speed_10 = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", int'({rx_valid, rx_er, rx_sof, rx_eof, stat_align_err, stat_preamble_err, rx_data}), 0);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) drive_dibit(1'b0, 2'b00, 1'b0, 1);

        // ---------------- table-driven vectors ----------------
        for (int v = 0; v < 9; v++) begin
            snap();
            drive_frame(vecs[v].pre_len, vecs[v].nbytes, vecs[v].data, vecs[v].err_mask,
                        vecs[v].tog_mask, vecs[v].tail, 4, 1);
            check_frame(vecs[v].exp_nvalid, vecs[v].exp_data, vecs[v].exp_er, vecs[v].exp_eof,
                        vecs[v].exp_align, vecs[v].exp_pre, vecs[v].tail, 1'b1);
        end

        // ---------------- back-to-back frames, one-dibit gap ----------------
        snap();
        drive_frame(31, 3, 64'h00AB3412, 32'h0, 32'h0, 0, 1, 1);
        drive_frame(31, 1, 64'h5C, 32'h0, 32'h0, 0, 4, 1);
        bb_exp = '{8'h12, 8'h34, 8'hAB, 8'h5C};
        check("b2b_valid_count", mon_data.size() - base_v, 4);
        for (int i = 0; i < 4 && base_v + i < mon_data.size(); i++) begin
            check("b2b_rx_data", int'(mon_data[base_v+i]), int'(bb_exp[i]));
            check("b2b_rx_sof", int'(mon_sof[base_v+i]), (i == 0 || i == 3) ? 1 : 0);
        end
        check("b2b_eof_count", eof_cnt - base_eof, 2);

        // ---------------- randomised frames vs frame-level model ----------------
        for (int f = 0; f < 30; f++) begin
            r_pre  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(33, 40)) : int'($urandom_range(1, 32));
            r_nb   = $urandom_range(0, 6);
            r_data = {$urandom, $urandom};
            r_err  = $urandom & $urandom & $urandom;
            r_tog  = $urandom & 32'hAAAA_AAAA;
            r_tail = $urandom_range(0, 1) * 2;
            // Model: a legal preamble yields every full byte, and each rx_er is
            // the OR of the rxer flags on that byte's four dibits. Exactly one
            // eof follows, with an alignment error when a half byte trails.
            // An over-long preamble yields only the preamble error.
            m_data = '0;
            m_er   = '0;
            if (r_pre <= 32) begin
                m_nv    = r_nb;
                m_eof   = 1;
                m_align = (r_tail == 2) ? 1 : 0;
                m_pre   = 0;
                for (int b = 0; b < r_nb; b++) begin
                    m_data[8*b +: 8] = r_data[8*b +: 8];
                    m_er[b]          = |r_err[4*b +: 4];
                end
            end else begin
                m_nv = 0; m_eof = 0; m_align = 0; m_pre = 1;
            end
            snap();
            drive_frame(r_pre, r_nb, r_data, r_err, r_tog, r_tail, 4, 1);
            check_frame(m_nv, m_data, m_er, m_eof, m_align, m_pre, r_tail, 1'b1);
        end

        // ---------------- reset asserted mid-frame ----------------
        snap();
        for (int p = 0; p < 31; p++) drive_dibit(1'b1, 2'b01, 1'b0, 1);
        drive_dibit(1'b1, 2'b11, 1'b0, 1);
        drive_dibit(1'b1, 2'b10, 1'b0, 1);   // byte 0x66
        drive_dibit(1'b1, 2'b01, 1'b0, 1);
        drive_dibit(1'b1, 2'b10, 1'b0, 1);
        drive_dibit(1'b1, 2'b01, 1'b0, 1);
        drive_dibit(1'b1, 2'b10, 1'b0, 1);   // two dibits of byte 2
        drive_dibit(1'b1, 2'b10, 1'b0, 1);
        #3 reset_n = 1'b0;
        #1;
        check("midframe_reset_outputs", int'({rx_valid, rx_er, rx_sof, rx_eof, stat_align_err, stat_preamble_err, rx_data}), 0);
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) drive_dibit(1'b1, 2'b11, 1'b0, 1);
        for (int i = 0; i < 4; i++) drive_dibit(1'b0, 2'b00, 1'b0, 1);
        check("reset_frame_valid_count", mon_data.size() - base_v, 1);
        if (mon_data.size() > base_v) check("reset_frame_byte", int'(mon_data[base_v]), 'h66);
        check("reset_frame_eof_count", eof_cnt - base_eof, 0);
        snap();
        drive_frame(31, 3, 64'h00AB3412, 32'h0, 32'h0, 0, 4, 1);
        check_frame(3, 64'h00AB3412, 8'h00, 1, 0, 0, 0, 1'b1);

`ifdef RMII_RX_10M_EN
        // ---------------- 10 Mb/s: each dibit held 10 clocks ----------------
        speed_10 = 1'b1;
        for (int i = 0; i < 2; i++) drive_dibit(1'b0, 2'b00, 1'b0, 10);
        snap();
        drive_frame(31, 3, 64'h00AB3412, 32'h0, 32'h0, 0, 4, 10);
        check_frame(3, 64'h00AB3412, 8'h00, 1, 0, 0, 0, 1'b0);
        speed_10 = 1'b0;
`endif

        check("valid_eof_overlap", ovl_cnt, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
